// File: rtl/dem_element_decoder.sv
// DEM-DAC unit-element receive monitor: popcount decode, reference compare,
// per-element usage statistics and max-min spread.
module dem_element_decoder #(
  parameter int NUM_ELEM   = 16,
  parameter int CODE_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  input  logic [NUM_ELEM-1:0]         elem_i,
  input  logic [CODE_WIDTH-1:0]       ref_i,
  input  logic                        clear_i,
  input  logic [$clog2(NUM_ELEM)-1:0] cnt_sel_i,
  output logic                        valid_o,
  output logic [CODE_WIDTH-1:0]       code_o,
  output logic                        mismatch_o,
  output logic [CNT_WIDTH-1:0]        err_cnt_o,
  output logic [CNT_WIDTH-1:0]        usage_o,
  output logic [CNT_WIDTH-1:0]        spread_o,
  output logic                        sat_o
);

  localparam int N2 = 1 << $clog2(NUM_ELEM);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  logic                  s1_valid_q;
  logic [NUM_ELEM-1:0]   s1_elem_q;
  logic [CODE_WIDTH-1:0] s1_ref_q;

  logic                  valid_q;
  logic                  mismatch_q, mismatch_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;

  cnt_t cnt_q [NUM_ELEM];
  cnt_t cnt_d [NUM_ELEM];
  cnt_t err_q, err_d;
  cnt_t spread_q, spread_d;
  logic sat_q, sat_d;

  cnt_t mx [2*N2-1];
  cnt_t mn [2*N2-1];

  always_comb begin
    code_d = '0;
    for (int k = 0; k < NUM_ELEM; k++)
      code_d = code_d + CODE_WIDTH'(s1_elem_q[k]);
    mismatch_d = s1_valid_q && (code_d != s1_ref_q);
  end

  // Clear overrides the increment of the sample reaching stage 2
  always_comb begin
    err_d = err_q;
    sat_d = sat_q;
    for (int k = 0; k < NUM_ELEM; k++) begin
      cnt_d[k] = cnt_q[k];
      if (s1_valid_q && s1_elem_q[k] && cnt_q[k] != '1)
        cnt_d[k] = cnt_q[k] + cnt_t'(1);
      if (cnt_d[k] == '1)
        sat_d = 1'b1;
    end
    if (mismatch_d && err_q != '1)
      err_d = err_q + cnt_t'(1);
    if (clear_i) begin
      for (int k = 0; k < NUM_ELEM; k++)
        cnt_d[k] = '0;
      err_d = '0;
      sat_d = 1'b0;
    end
  end

  // Heap-ordered max/min tree; unused leaves mirror element 0
  always_comb begin
    for (int k = 0; k < N2; k++) begin
      mx[N2-1+k] = cnt_q[(k < NUM_ELEM) ? k : 0];
      mn[N2-1+k] = cnt_q[(k < NUM_ELEM) ? k : 0];
    end
    for (int i = N2 - 2; i >= 0; i--) begin
      mx[i] = (mx[2*i+1] > mx[2*i+2]) ? mx[2*i+1] : mx[2*i+2];
      mn[i] = (mn[2*i+1] < mn[2*i+2]) ? mn[2*i+1] : mn[2*i+2];
    end
    spread_d = mx[0] - mn[0];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_elem_q  <= '0;
      s1_ref_q   <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      code_q     <= '0;
      for (int k = 0; k < NUM_ELEM; k++)
        cnt_q[k] <= '0;
      err_q      <= '0;
      spread_q   <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_elem_q <= elem_i;
        s1_ref_q  <= ref_i;
      end
      valid_q    <= s1_valid_q;
      mismatch_q <= mismatch_d;
      if (s1_valid_q)
        code_q <= code_d;
      for (int k = 0; k < NUM_ELEM; k++)
        cnt_q[k] <= cnt_d[k];
      err_q    <= err_d;
      spread_q <= spread_d;
      sat_q    <= sat_d;
    end
  end

  assign valid_o    = valid_q;
  assign code_o     = code_q;
  assign mismatch_o = mismatch_q;
  assign err_cnt_o  = err_q;
  assign usage_o    = cnt_q[cnt_sel_i];
  assign spread_o   = spread_q;
  assign sat_o      = sat_q;

endmodule

// File: tb/tb_dem_element_decoder.sv
// Bench for dem_element_decoder: directed scenarios plus random traffic
// against a sample-level statistics model.
module tb_dem_element_decoder;

  localparam int N   = 16;
  localparam int CW  = 5;
  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [N-1:0]  elem_i;
  logic [CW-1:0] ref_i;
  logic          clear_i;
  logic [3:0]    cnt_sel_i;
  logic          valid_o;
  logic [CW-1:0] code_o;
  logic          mismatch_o;
  logic [W-1:0]  err_cnt_o;
  logic [W-1:0]  usage_o;
  logic [W-1:0]  spread_o;
  logic          sat_o;

  dem_element_decoder #(
    .NUM_ELEM(N), .CODE_WIDTH(CW), .CNT_WIDTH(W)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i),
    .elem_i(elem_i), .ref_i(ref_i), .clear_i(clear_i),
    .cnt_sel_i(cnt_sel_i), .valid_o(valid_o), .code_o(code_o),
    .mismatch_o(mismatch_o), .err_cnt_o(err_cnt_o),
    .usage_o(usage_o), .spread_o(spread_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // sample-level model state
  int           usage [N];
  int           m_err, m_spread, m_code;
  bit           m_sat, m_valid, m_mis;
  bit           p_v;
  logic [N-1:0] p_e;
  int           p_r;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (usage[k]) usage[k] = 0;
    m_err = 0; m_spread = 0; m_code = 0;
    m_sat = 0; m_valid = 0; m_mis = 0;
    p_v = 0; p_e = '0; p_r = 0;
  endtask

  task automatic model_edge(input bit v, input logic [N-1:0] e,
                            input int r, input bit clr);
    int mx, mn;
    mx = usage[0]; mn = usage[0];
    foreach (usage[k]) begin
      if (usage[k] > mx) mx = usage[k];
      if (usage[k] < mn) mn = usage[k];
    end
    m_spread = mx - mn;
    if (p_v) begin
      m_code  = $countones(p_e);
      m_mis   = (m_code != p_r);
      m_valid = 1;
      foreach (usage[k])
        if (p_e[k] && usage[k] < MAX) usage[k]++;
      if (m_mis && m_err < MAX) m_err++;
    end else begin
      m_valid = 0;
      m_mis   = 0;
    end
    foreach (usage[k]) if (usage[k] == MAX) m_sat = 1;
    if (clr) begin
      foreach (usage[k]) usage[k] = 0;
      m_err = 0;
      m_sat = 0;
    end
    p_v = v; p_e = e; p_r = r;
  endtask

  task automatic compare_all();
    chk("valid",  32'(valid_o),    32'(m_valid));
    chk("code",   32'(code_o),     32'(m_code));
    chk("mis",    32'(mismatch_o), 32'(m_mis));
    chk("err",    32'(err_cnt_o),  32'(m_err));
    chk("spread", 32'(spread_o),   32'(m_spread));
    chk("sat",    32'(sat_o),      32'(m_sat));
    chk("usage",  32'(usage_o),    32'(usage[cnt_sel_i]));
  endtask

  task automatic step(input bit v, input logic [N-1:0] e,
                      input int r, input bit clr, input int sel);
    @(negedge clk);
    valid_i   = v;
    elem_i    = e;
    ref_i     = CW'(r);
    clear_i   = clr;
    cnt_sel_i = 4'(sel);
    @(posedge clk);
    model_edge(v, e, r, clr);
    #1;
    compare_all();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"},  32'(valid_o),    32'd0);
    chk({tag, "_code"},   32'(code_o),     32'd0);
    chk({tag, "_mis"},    32'(mismatch_o), 32'd0);
    chk({tag, "_err"},    32'(err_cnt_o),  32'd0);
    chk({tag, "_usage"},  32'(usage_o),    32'd0);
    chk({tag, "_spread"}, 32'(spread_o),   32'd0);
    chk({tag, "_sat"},    32'(sat_o),      32'd0);
  endtask

  initial begin
    logic [N-1:0] e;
    int r;
    reset_i = 1'b1; valid_i = 1'b0; elem_i = '0;
    ref_i = '0; clear_i = 1'b0; cnt_sel_i = '0;
    model_reset();
    #1;
    chk_zero("por");
    @(negedge clk);
    reset_i = 1'b0;

    // match, latency two
    step(1, 16'h00FF, 8, 0, 0);
    chk("lat_n1_valid", 32'(valid_o), 32'd0);
    step(0, '0, 0, 0, 0);
    chk("lat_n2_valid", 32'(valid_o),    32'd1);
    chk("lat_n2_code",  32'(code_o),     32'd8);
    chk("lat_n2_mis",   32'(mismatch_o), 32'd0);
    chk("lat_n2_err",   32'(err_cnt_o),  32'd0);
    step(0, '0, 0, 0, 0);
    chk("lat_n3_valid", 32'(valid_o), 32'd0);

    // mismatch then full scale
    step(1, 16'h000F, 5, 0, 0);
    step(1, 16'hFFFF, 16, 0, 0);
    chk("mm_code", 32'(code_o),     32'd4);
    chk("mm_mis",  32'(mismatch_o), 32'd1);
    chk("mm_err",  32'(err_cnt_o),  32'd1);
    step(0, '0, 0, 0, 0);
    chk("fs_code", 32'(code_o),     32'd16);
    chk("fs_mis",  32'(mismatch_o), 32'd0);
    chk("fs_err",  32'(err_cnt_o),  32'd1);

    // walking one-hot usage
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(1, N'(1) << i, 1, 0, i);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      step(0, '0, 0, 0, i);
      chk($sformatf("walk_use%0d", i), 32'(usage_o), 32'd1);
    end
    chk("walk_spread", 32'(spread_o), 32'd0);
    step(1, 16'h0001, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    chk("extra_use0", 32'(usage_o), 32'd2);
    step(0, '0, 0, 0, 0);
    chk("extra_spread", 32'(spread_o), 32'd1);
    step(0, '0, 0, 0, 0);
    chk("extra_spread2", 32'(spread_o), 32'd1);

    // saturation
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < MAX; i++) step(1, 16'h0001, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    chk("sat_use0", 32'(usage_o), 32'd15);
    chk("sat_flag", 32'(sat_o),   32'd1);
    for (int i = 0; i < 5; i++) step(1, 16'h0001, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    chk("sat_hold_use0", 32'(usage_o), 32'd15);
    chk("sat_hold_flag", 32'(sat_o),   32'd1);

    // clear colliding with a stage-2 sample
    step(1, 16'h0003, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    chk("clr_valid", 32'(valid_o),    32'd1);
    chk("clr_mis",   32'(mismatch_o), 32'd1);
    chk("clr_use0",  32'(usage_o),    32'd0);
    chk("clr_err",   32'(err_cnt_o),  32'd0);
    chk("clr_sat",   32'(sat_o),      32'd0);
    step(0, '0, 0, 0, 1);
    chk("clr_use1", 32'(usage_o), 32'd0);

    // reset in the middle of traffic
    step(1, 16'h0F0F, 8, 0, 0);
    step(1, 16'h00F0, 3, 0, 0);
    step(1, 16'h3000, 2, 0, 4);
    #2;
    reset_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0;
    #1;
    chk_zero("rst_mid");
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;
    step(0, '0, 0, 0, 0);
    chk("rst_no_pulse1", 32'(valid_o), 32'd0);
    step(0, '0, 0, 0, 0);
    chk("rst_no_pulse2", 32'(valid_o), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: e = N'($urandom);
        1: e = N'(1) << $urandom_range(0, N - 1);
        default: e = N'($urandom) & N'($urandom) & N'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) r = $countones(e);
      else r = $urandom_range(0, N);
      step(($urandom_range(0, 3) != 0), e, r,
           ($urandom_range(0, 39) == 0), $urandom_range(0, N - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dem_element_decoder.md
Name: dem_element_decoder

Overview:
- Receive end of the DEM-DAC unit-element interface.
- Takes the per-cycle unit-element enable vector produced by the DEM switching tree and reconstructs the thermometer code by popcount. Compares the code with the expected code, counts mismatches and tracks per-element usage, so element-selection spread can be measured on-chip and in simulation.
- Sits beside the DEM encoder output, in the verification/monitor path of the DAC.

Parameters:
- NUM_ELEM, 16, number of unit elements (element vector width), >= 2
- CODE_WIDTH, 5, code width; must equal $clog2(NUM_ELEM+1)
- CNT_WIDTH, 16, width of each per-element usage counter and of the error counter

Ports:
- clk_i  input  1  clock; all state changes on rising edge
- reset_i  input  1  asynchronous, active-high reset
- valid_i  input  1  elem_i/ref_i carry a sample this cycle
- elem_i  input  NUM_ELEM  unit-element enables, bit k = element k driven
- ref_i  input  CODE_WIDTH  expected code for this sample (unsigned)
- clear_i  input  1  synchronous clear of statistics
- cnt_sel_i  input  $clog2(NUM_ELEM)  element index for usage readback
- valid_o  output  1  code_o/mismatch_o valid
- code_o  output  CODE_WIDTH  reconstructed code = popcount(elem_i)
- mismatch_o  output  1  code_o != ref_i for this sample
- err_cnt_o  output  CNT_WIDTH  saturating count of mismatching samples
- usage_o  output  CNT_WIDTH  usage counter of element cnt_sel_i (combinational mux)
- spread_o  output  CNT_WIDTH  max minus min over all usage counters
- sat_o  output  1  sticky: some usage counter reached all-ones

Behaviour:
- Reset (reset_i=1, asynchronous, takes effect immediately with no clock edge): every register and output is 0, including the pipeline, counters, spread_o and sat_o. Operation resumes on the first edge after deassertion.
- Stage 1, edge E0: if valid_i=1, capture elem_i and ref_i into stage-1 registers and set s1_valid. Otherwise s1_valid=0.
- Stage 2, edge E1, when s1_valid=1:
  - code_o = popcount(s1_elem); mismatch_o = (code_o != s1_ref); valid_o=1.
  - Each usage counter k increments if s1_elem[k]=1.
  - err_cnt_o increments if there is a mismatch.
- When s1_valid=0 at E1: valid_o=0 and mismatch_o=0. code_o holds its last value.
- Latency: valid_i high in cycle n gives valid_o high in cycle n+2. Full throughput, one sample per clock, no backpressure.
- Spread, edge E2: spread_o = max(cnt[k]) - min(cnt[k]), registered from the counters one edge after they update. The computation is a combinational reduction tree; no iterative scan.
- Saturation: usage counters and err_cnt_o stop at 2^CNT_WIDTH-1 and never wrap. sat_o sets at the edge where any usage counter reaches all-ones, and stays set until clear_i or reset.
- clear_i=1 at an edge:
  - Usage counters, err_cnt_o and sat_o are set to 0. Clear wins over any increment at the same edge, so that sample's usage and error contribution is dropped.
  - The pipeline (s1, code_o, valid_o, mismatch_o) is unaffected.
  - spread_o reads 0 at the following edge.
- Samples already in flight when clear deasserts count normally.
- elem_i with all bits set gives code NUM_ELEM; CODE_WIDTH holds this without overflow.
- Reset asserted mid-stream: in-flight samples are discarded; valid_o never pulses for them after reset.

Test Plan:
- Reset: run traffic, assert reset_i between edges. All outputs must read 0 within the same timestep, before any clock edge.
- Match, latency 2: valid_i=1, elem_i=16'h00FF, ref_i=8 in cycle n. Cycle n+2 must show valid_o=1, code_o=8, mismatch_o=0, err_cnt_o=0. valid_o must be 0 in cycles n+1 and n+3.
- Mismatch and full scale: elem_i=16'h000F with ref_i=5 gives code_o=4, mismatch_o=1, err_cnt_o=1. The next sample, elem_i=16'hFFFF with ref_i=16, gives code_o=16, mismatch_o=0, err_cnt_o stays 1.
- Usage and spread:
  - 16 back-to-back one-hot samples, walking bit 0..15: usage_o=1 for every cnt_sel_i, and spread_o=0.
  - One further sample of 16'h0001: usage_o[0]=2 and spread_o=1, two edges after that sample's stage-2 edge.
- Saturation (CNT_WIDTH=4): 15 samples of 16'h0001. sat_o=1 and usage_o[0]=15. Five more identical samples leave usage_o[0]=15 and sat_o=1.
- Clear collision: clear_i=1 on the same edge where a sample with elem_i=16'h0003 and ref_i=0 reaches stage 2. Afterwards usage_o[0]=usage_o[1]=0, err_cnt_o=0 and sat_o=0, while valid_o=1 and mismatch_o=1 still appear for that sample.
